// File: rtl/cic_comb_chain.sv
// CIC comb section: N cascaded comb stages, y[n] = x[n] - x[n-M], run at the
// decimated sample rate. Each stage advances only on a qualified sample. The
// valid strobe and a "primed" flag travel down the pipe alongside the data.
// Results wrap modulo 2^DATA_WIDTH. The output keeps the top OUT_WIDTH bits.
module cic_comb_chain #(
  parameter int N          = 3,
  parameter int M          = 1,
  parameter int DATA_WIDTH = 12,
  parameter int OUT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic                  x_valid,
  output logic [OUT_WIDTH-1:0]  y,
  output logic                  y_valid,
  output logic                  y_primed
);

  localparam int WARM = N * M;
  localparam int CW   = $clog2(WARM + 1);
  localparam logic [CW-1:0] WARM_C = CW'(WARM);

  logic [DATA_WIDTH-1:0] stage_q [N];
  logic [DATA_WIDTH-1:0] stage_d [N];
  logic [DATA_WIDTH-1:0] hist_q  [N][M];
  logic [DATA_WIDTH-1:0] hist_d  [N][M];
  logic [N-1:0]          valid_q, valid_d;
  logic [N-1:0]          primed_q, primed_d;
  logic [CW-1:0]         count_q, count_d;

  logic [DATA_WIDTH-1:0] s_in [N];
  logic [N-1:0]          v_in;
  logic [N-1:0]          p_in;

  // Route each stage's input: stage 0 sees the external sample, later stages see their predecessor
  always_comb begin
    for (int k = 0; k < N; k++) begin
      s_in[k] = '0;
    end
    v_in = '0;
    p_in = '0;
    s_in[0] = x;
    v_in[0] = x_valid;
    p_in[0] = x_valid && (count_q == WARM_C);
    for (int k = 1; k < N; k++) begin
      s_in[k] = stage_q[k-1];
      v_in[k] = valid_q[k-1];
      p_in[k] = primed_q[k-1];
    end
  end

  // Next state: difference and delay-line shift on qualified samples, valid/primed always advance, clear flushes
  always_comb begin
    stage_d  = stage_q;
    hist_d   = hist_q;
    valid_d  = v_in;
    primed_d = p_in;
    count_d  = count_q;

    if (x_valid && (count_q != WARM_C)) begin
      count_d = count_q + CW'(1);
    end

    for (int k = 0; k < N; k++) begin
      if (v_in[k]) begin
        stage_d[k]   = s_in[k] - hist_q[k][M-1];
        hist_d[k][0] = s_in[k];
        for (int i = 1; i < M; i++) begin
          hist_d[k][i] = hist_q[k][i-1];
        end
      end
    end

    if (clear) begin
      valid_d  = '0;
      primed_d = '0;
      count_d  = '0;
      for (int k = 0; k < N; k++) begin
        stage_d[k] = '0;
        for (int i = 0; i < M; i++) begin
          hist_d[k][i] = '0;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      primed_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < N; k++) begin
        stage_q[k] <= '0;
        for (int i = 0; i < M; i++) begin
          hist_q[k][i] <= '0;
        end
      end
    end else begin
      valid_q  <= valid_d;
      primed_q <= primed_d;
      count_q  <= count_d;
      stage_q  <= stage_d;
      hist_q   <= hist_d;
    end
  end

  assign y        = stage_q[N-1][DATA_WIDTH-1 -: OUT_WIDTH];
  assign y_valid  = valid_q[N-1];
  assign y_primed = primed_q[N-1];

  // Truncated LSBs of the last stage are intentionally dropped
  if (OUT_WIDTH < DATA_WIDTH) begin : gTrunc
    logic unused_lsbs;
    assign unused_lsbs = ^stage_q[N-1][DATA_WIDTH-OUT_WIDTH-1:0];
  end

endmodule

// File: tb/tb_cic_comb_chain.sv
// Bench for cic_comb_chain. It drives several parameterisations from one shared
// stimulus stream. Each instance keeps its own history of accepted samples. The
// expected output is the closed-form N-th order difference
// sum_j (-1)^j C(N,j) x[n-jM]. The expected value is queued when a sample is
// issued and compared when the instance raises y_valid.
module tb_cic_comb_chain;

  localparam int PERIOD = 10;
  localparam int NDUT   = 5;
  localparam int CFG_N  [NDUT] = '{1, 2, 3, 1, 2};
  localparam int CFG_M  [NDUT] = '{1, 1, 2, 1, 3};
  localparam int CFG_OW [NDUT] = '{12, 12, 12, 8, 10};

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [11:0] x;
  logic        x_valid;
  logic        endCheck;

  int nTests = 0;
  int nFail  = 0;

  // Free-running clock
  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  // Exact binomial coefficient
  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int i = 1; i <= k; i++) begin
      r = r * (n - k + i) / i;
    end
    return r;
  endfunction

  // One comparison: counts it and reports a failure line on mismatch
  task automatic checkOutput(input string name, input int g, input longint act, input longint exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s dut%0d @%0t: got %0h, expected %0h", name, g, $time, act, exp);
    end
  endtask

  // Present one cycle of inputs, changed just after the rising edge
  task automatic applyStimulus(input logic [11:0] xv, input logic v, input logic c);
    @(posedge clk);
    #1;
    x       = xv;
    x_valid = v;
    clear   = c;
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    localparam int GN  = CFG_N[g];
    localparam int GM  = CFG_M[g];
    localparam int GOW = CFG_OW[g];

    typedef struct {
      logic [GOW-1:0] y;
      logic           p;
      longint         due;
    } exp_t;

    logic [GOW-1:0] yOut;
    logic           yValid;
    logic           yPrimed;

    exp_t           expq[$];
    int             hist[$];
    int             cnt = 0;
    logic [GOW-1:0] lastY = '0;
    bit             endDone = 1'b0;

    cic_comb_chain #(
      .N(GN), .M(GM), .DATA_WIDTH(12), .OUT_WIDTH(GOW)
    ) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .x(x), .x_valid(x_valid),
      .y(yOut), .y_valid(yValid), .y_primed(yPrimed)
    );

    // Monitor on the falling edge: check outputs, then record the sample the next rising edge will take
    always @(negedge clk) begin
      exp_t        e;
      exp_t        nx;
      int          sum;
      logic [11:0] full;

      if (!rst_n) begin
        expq.delete();
        hist.delete();
        cnt   = 0;
        lastY = '0;
      end

      if (yValid) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected y_valid", g, 1, 0);
        end else begin
          e = expq.pop_front();
          checkOutput("y value", g, longint'(yOut), longint'(e.y));
          checkOutput("y_primed", g, longint'(yPrimed), longint'(e.p));
          checkOutput("latency", g, longint'($time), e.due);
          lastY = e.y;
        end
      end else begin
        checkOutput("y hold", g, longint'(yOut), longint'(lastY));
        checkOutput("idle primed", g, longint'(yPrimed), 0);
      end

      if (rst_n && clear) begin
        expq.delete();
        hist.delete();
        cnt   = 0;
        lastY = '0;
      end else if (rst_n && x_valid) begin
        hist.push_front(int'(x));
        if (hist.size() > GN*GM + 1) void'(hist.pop_back());
        sum = 0;
        for (int j = 0; j <= GN; j++) begin
          if (j*GM < hist.size()) begin
            if (j % 2 == 1) sum = sum - binom(GN, j) * hist[j*GM];
            else            sum = sum + binom(GN, j) * hist[j*GM];
          end
        end
        full   = 12'(sum);
        nx.y   = full[11 -: GOW];
        nx.p   = (cnt >= GN*GM);
        nx.due = longint'($time) + longint'(GN*PERIOD);
        cnt++;
        expq.push_back(nx);
      end

      if (endCheck && !endDone) begin
        endDone = 1'b1;
        checkOutput("queue drained", g, longint'(expq.size()), 0);
      end
    end
  end

  // Directed scenarios followed by randomized traffic, clears and a mid-stream reset
  initial begin
    x        = '0;
    x_valid  = 1'b0;
    clear    = 1'b0;
    rst_n    = 1'b0;
    endCheck = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) applyStimulus(12'h000, 1'b0, 1'b0);

    applyStimulus(12'd5, 1'b1, 1'b0);
    applyStimulus(12'd7, 1'b1, 1'b0);
    applyStimulus(12'd3, 1'b1, 1'b0);
    repeat (8) applyStimulus(12'h000, 1'b0, 1'b0);
    applyStimulus(12'h000, 1'b0, 1'b1);

    applyStimulus(12'h7FF, 1'b1, 1'b0);
    applyStimulus(12'h800, 1'b1, 1'b0);
    repeat (4) applyStimulus(12'h000, 1'b0, 1'b0);
    applyStimulus(12'h000, 1'b0, 1'b1);

    applyStimulus(12'h7F0, 1'b1, 1'b0);
    repeat (4) applyStimulus(12'h000, 1'b0, 1'b0);
    applyStimulus(12'h000, 1'b0, 1'b1);

    applyStimulus(12'd1, 1'b1, 1'b0);
    repeat (6) applyStimulus(12'd0, 1'b1, 1'b0);
    repeat (4) applyStimulus(12'h000, 1'b0, 1'b0);
    applyStimulus(12'h000, 1'b0, 1'b1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus((i == 0) ? 12'd1 : 12'd0, 1'b1, 1'b0);
      repeat (3) applyStimulus(12'h000, 1'b0, 1'b0);
    end
    applyStimulus(12'h000, 1'b0, 1'b1);

    repeat (12) applyStimulus(12'd100, 1'b1, 1'b0);
    repeat (4) applyStimulus(12'h000, 1'b0, 1'b0);

    applyStimulus(12'h123, 1'b1, 1'b0);
    applyStimulus(12'h456, 1'b1, 1'b1);
    repeat (4) applyStimulus(12'h000, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(12'($urandom), $urandom_range(3) != 0, $urandom_range(40) == 0);
    end

    repeat (3) applyStimulus(12'($urandom), 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    x_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      applyStimulus(12'($urandom), $urandom_range(7) != 0, $urandom_range(60) == 0);
    end

    repeat (20) applyStimulus(12'h000, 1'b0, 1'b0);
    endCheck = 1'b1;
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
